// File: rtl/ahblite_timer.sv
// AHB-Lite slave timer: prescaled 32-bit down-counter with periodic/one-shot
// modes and a level interrupt. Zero wait states, always OKAY.
module ahblite_timer #(
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        TIMER_IRQ
);

  localparam int unsigned PW        = PRESCALE_WIDTH;
  localparam int unsigned AW        = 3;
  localparam logic [AW-1:0] A_CTRL     = 3'd0;
  localparam logic [AW-1:0] A_LOAD     = 3'd1;
  localparam logic [AW-1:0] A_VALUE    = 3'd2;
  localparam logic [AW-1:0] A_STATUS   = 3'd3;
  localparam logic [AW-1:0] A_PRESCALE = 3'd4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
  } dphase_t;

  dphase_t       dp;
  logic          dp_valid;
  logic [2:0]    ctrl;
  logic [31:0]   load;
  logic [31:0]   value;
  logic          irq;
  logic [PW-1:0] prescale;
  logic [PW-1:0] pcnt;

  logic accept, wr, tick, irq_set;
  logic wr_ctrl, wr_load, wr_status, wr_prescale;
  logic ctrl_en, ctrl_ie, ctrl_periodic;
  logic unused_bits;

  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign accept        = HSEL & HTRANS[1] & HREADY;
  assign wr            = dp_valid & dp.write;
  assign wr_ctrl       = wr & (dp.addr == A_CTRL);
  assign wr_load       = wr & (dp.addr == A_LOAD);
  assign wr_status     = wr & (dp.addr == A_STATUS);
  assign wr_prescale   = wr & (dp.addr == A_PRESCALE);
  assign ctrl_en       = ctrl[0];
  assign ctrl_ie       = ctrl[1];
  assign ctrl_periodic = ctrl[2];
  assign tick          = ctrl_en & (pcnt == prescale);
  assign irq_set       = tick & (value == 32'd0);

  // Address-phase latch; any non-accepted cycle closes the data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp       <= '0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp.addr  <= HADDR[4:2];
        dp.write <= HWRITE;
      end
    end
  end

  // Register file and counter; bus writes take priority over timer events
  // except for the IRQ set, which beats a same-cycle W1C.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl     <= '0;
      load     <= '0;
      value    <= '0;
      irq      <= 1'b0;
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr_ctrl)
        ctrl <= HWDATA[2:0];
      else if (irq_set && !ctrl_periodic)
        ctrl[0] <= 1'b0;

      if (wr_load)
        load <= HWDATA;

      if (wr_prescale)
        prescale <= HWDATA[PW-1:0];

      if (wr_load || !ctrl_en || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + PW'(1);

      if (wr_load)
        value <= HWDATA;
      else if (tick) begin
        if (value != 32'd0)
          value <= value - 32'd1;
        else if (ctrl_periodic)
          value <= load;
      end

      if (irq_set)
        irq <= 1'b1;
      else if (wr_status && HWDATA[0])
        irq <= 1'b0;
    end
  end

  // Read mux is combinational so a write followed by a read sees the new value.
  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid && !dp.write) begin
      case (dp.addr)
        A_CTRL:     HRDATA = {29'd0, ctrl};
        A_LOAD:     HRDATA = load;
        A_VALUE:    HRDATA = value;
        A_STATUS:   HRDATA = {31'd0, irq};
        A_PRESCALE: HRDATA = 32'(prescale);
        default:    HRDATA = 32'd0;
      endcase
    end
  end

  assign TIMER_IRQ = irq & ctrl_ie;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: doc/ahblite_timer.md
# ahblite_timer

AHB-Lite slave timer peripheral that sits on one peripheral port of the SoC AHB-Lite interconnect (any of P0..P3), downstream of the address decoder and slave response mux. It provides a prescaled 32-bit down-counter with periodic and one-shot modes, and a level interrupt. All register access completes with zero wait states and an OKAY response.

## Interface
- PRESCALE_WIDTH, 8, width of the prescaler register and counter
- HCLK  in  1  system clock; all state changes on its rising edge
- HRESET  in  1  asynchronous reset, active-high; clears all state immediately
- HSEL  in  1  slave select from the interconnect decoder
- HADDR  in  32  address; only HADDR[4:2] decoded
- HTRANS  in  2  transfer type; a transfer is valid when HTRANS[1]=1
- HSIZE  in  3  ignored; every write is a full 32-bit word
- HPROT  in  4  ignored
- HWRITE  in  1  1 = write, 0 = read
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-wide ready from the interconnect
- HREADYOUT  out  1  constant 1
- HRDATA  out  32  read data, valid in the data phase
- HRESP  out  1  constant 0 (OKAY)
- TIMER_IRQ  out  1  interrupt: STATUS.IRQ & CTRL.IE

## Operation
- Register map, offset from HADDR[4:2]:
  - 0x00 CTRL, RW: bit0 EN, bit1 IE, bit2 PERIODIC.
  - 0x04 LOAD, RW, 32 bits. A write also sets VALUE to the written data and clears the prescaler counter.
  - 0x08 VALUE, RO. Writes are ignored.
  - 0x0C STATUS: bit0 IRQ. Reads return the flag; writing 1 to bit0 clears it.
  - 0x10 PRESCALE, RW, low PRESCALE_WIDTH bits.
  - 0x14..0x1C: read 0, writes ignored.
  - Unused bits read 0.
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register the offset, the write flag and a valid bit.
  - Non-accepted cycles clear the valid bit.
  - IDLE and BUSY transfers have no effect.
- Write commit: in the data phase, HWDATA is written to the latched register at the end of that cycle.
- Read data: HRDATA is combinational from the latched offset and the current register contents. HRDATA is 0 when no read data phase is active.
- Prescaler:
  - PCNT increments each cycle while EN=1.
  - tick = EN & (PCNT == PRESCALE); PCNT returns to 0 on tick.
  - PCNT holds at 0 while EN=0.
- Counter, on each tick:
  - If VALUE != 0: VALUE <= VALUE - 1.
  - If VALUE == 0: set STATUS.IRQ.
    - PERIODIC=1: VALUE <= LOAD.
    - PERIODIC=0: clear EN; VALUE stays 0.
- Collisions within one cycle:
  - An IRQ set and a W1C of STATUS in the same cycle: the set wins, and IRQ stays 1.
  - A LOAD write and a tick in the same cycle: the LOAD write wins, VALUE = new LOAD and PCNT = 0.
  - A CTRL write and a one-shot auto-clear of EN in the same cycle: the CTRL write wins.
- VALUE never wraps below 0. Arithmetic is unsigned 32-bit.

## Timing
- Reset values:
  - CTRL, LOAD, VALUE, STATUS, PRESCALE, PCNT and the data-phase latch are all 0.
  - HRDATA = 0, TIMER_IRQ = 0.
  - HREADYOUT = 1, HRESP = 0.
- Write sequence: address phase in cycle N, data phase in cycle N+1, register updated at the rising edge ending N+1.
- Back-to-back write then read of the same register returns the new value in the read data phase (N+2). No stall is needed.
- IRQ period in periodic mode: (LOAD+1)*(PRESCALE+1) cycles.
- TIMER_IRQ rises one cycle after the tick at VALUE == 0. It is registered through STATUS.IRQ.
- Enabling EN with VALUE = 0: the first tick immediately sets IRQ.
- Reset asserted mid-operation:
  - All state is cleared asynchronously.
  - A pending data-phase write is discarded.
  - Any access whose address phase occurred before reset deassertion is ignored.

## Test plan
- Reset: assert HRESET mid-count. All registers read 0, HREADYOUT=1, HRESP=0, TIMER_IRQ=0.
- Periodic mode:
  - Stimulus: PRESCALE=0, LOAD=3, CTRL=0x7.
  - VALUE sequence 3,2,1,0,3,...; IRQ set every 4 cycles; TIMER_IRQ high after the first wrap.
  - W1C of STATUS drops TIMER_IRQ the next cycle.
- One-shot mode:
  - Stimulus: PRESCALE=1, LOAD=2, CTRL=0x3.
  - IRQ set 6 cycles after enable; CTRL reads 0x2; VALUE holds 0; no further IRQ.
- Collisions:
  - W1C of STATUS in the same cycle as a terminal tick: IRQ reads 1.
  - LOAD=0x10 written in the same cycle as a tick: VALUE reads 0x10.
- Bus behaviour:
  - Write LOAD=0xDEADBEEF then read LOAD back-to-back: returns 0xDEADBEEF.
  - Read of 0x14: returns 0.
  - Write to VALUE: ignored.
  - HTRANS=IDLE write with HSEL=1: no register change.
  - HSEL=0 transfer: no register change, HRDATA=0.
